// File: rtl/nonogram_pkg.sv
// nonogram_pkg: shared board limits, serializer state type and frame-length helper.
// SOLUTION_CHECKSUM_EN (when defined) adds one trailing XOR byte to every frame length.
package nonogram_pkg;

    localparam int MAX_ROWS = 11;
    localparam int MAX_COLS = 11;
    localparam int DIM_W    = $clog2(MAX_ROWS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } ser_state_t;

    // Header byte plus m rows of one or two bytes; an empty board carries no row bytes.
    function automatic logic [4:0] frame_len(input logic [7:0] rows, input logic [7:0] cols);
        logic [4:0] body;
        if (rows == 8'd0 || cols == 8'd0)
            body = 5'd0;
        else if (cols > 8'd8)
            body = 5'(rows * 8'd2);
        else
            body = rows[4:0];
`ifdef SOLUTION_CHECKSUM_EN
        return body + 5'd2;
`else
        return body + 5'd1;
`endif
    endfunction

endpackage

// File: rtl/row_byte_select.sv
// row_byte_select: picks byte k of row r from the latched board, zeroing columns at or beyond n.
module row_byte_select
    import nonogram_pkg::*;
#(
    parameter int ROWS  = MAX_ROWS,
    parameter int COLS  = MAX_COLS,
    parameter int SEL_W = DIM_W
) (
    input  logic [ROWS*COLS-1:0] solution,
    input  logic [SEL_W-1:0]     r,
    input  logic                 k,
    input  logic [SEL_W-1:0]     n,
    output logic [7:0]           row_byte
);

    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = $clog2(CELLS);

    always_comb begin
        int col;
        int idx;
        row_byte = 8'h00;
        col      = 0;
        idx      = 0;
        for (int b = 0; b < 8; b++) begin
            col = 8 * int'(k) + b;
            idx = int'(r) * COLS + col;
            if (col < int'(n) && col < COLS && idx < CELLS)
                row_byte[3'(b)] = solution[IDX_W'(idx)];
        end
    end

endmodule

// File: rtl/solution_serializer.sv
// solution_serializer: frames the solved board as a dimension header plus row-packed cell bytes for uart_tx.
// Define SOLUTION_CHECKSUM_EN to append an XOR-of-all-bytes checksum byte to every frame.
module solution_serializer
    import nonogram_pkg::*;
#(
    parameter int MAX_ROWS = nonogram_pkg::MAX_ROWS,
    parameter int MAX_COLS = nonogram_pkg::MAX_COLS,
    parameter int DIM_W    = $clog2(MAX_ROWS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic [MAX_ROWS*MAX_COLS-1:0] solution,
    input  logic [DIM_W-1:0]             m,
    input  logic [DIM_W-1:0]             n,
    input  logic                         tx_done,
    output logic                         send,
    output logic [7:0]                   byte_out,
    output logic                         busy,
    output logic                         done
);

    ser_state_t                   state;
    logic [MAX_ROWS*MAX_COLS-1:0] sol_q;
    logic [DIM_W-1:0]             n_q;
    logic [DIM_W-1:0]             r_q;
    logic                         k_q;
    logic [4:0]                   cnt_q;
    logic [4:0]                   total_q;
    logic [DIM_W-1:0]             m_clamp;
    logic [DIM_W-1:0]             n_clamp;
    logic [7:0]                   header;
    logic [7:0]                   row_byte;
    logic [7:0]                   next_byte;
`ifdef SOLUTION_CHECKSUM_EN
    logic [7:0]                   xor_q;
`endif

    assign m_clamp = (int'(m) > MAX_ROWS) ? DIM_W'(MAX_ROWS) : m;
    assign n_clamp = (int'(n) > MAX_COLS) ? DIM_W'(MAX_COLS) : n;
    assign header  = {4'(m_clamp), 4'(n_clamp)};

    row_byte_select #(
        .ROWS (MAX_ROWS),
        .COLS (MAX_COLS),
        .SEL_W(DIM_W)
    ) u_row_byte_select (
        .solution(sol_q),
        .r       (r_q),
        .k       (k_q),
        .n       (n_q),
        .row_byte(row_byte)
    );

    // (r_q, k_q) always points at the next row byte still to be emitted.
    always_comb begin
        next_byte = row_byte;
`ifdef SOLUTION_CHECKSUM_EN
        if (cnt_q + 5'd2 == total_q)
            next_byte = xor_q;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sol_q    <= '0;
            n_q      <= '0;
            r_q      <= '0;
            k_q      <= 1'b0;
            cnt_q    <= 5'd0;
            total_q  <= 5'd0;
            send     <= 1'b0;
            byte_out <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SOLUTION_CHECKSUM_EN
            xor_q    <= 8'h00;
`endif
        end else begin
            send <= 1'b0;
            done <= 1'b0;
`ifdef SOLUTION_CHECKSUM_EN
            if (send)
                xor_q <= xor_q ^ byte_out;
`endif
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        sol_q    <= solution;
                        n_q      <= n_clamp;
                        r_q      <= '0;
                        k_q      <= 1'b0;
                        cnt_q    <= 5'd0;
                        total_q  <= frame_len(8'(m_clamp), 8'(n_clamp));
                        byte_out <= header;
                        send     <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
`ifdef SOLUTION_CHECKSUM_EN
                        xor_q    <= 8'h00;
`endif
                    end
                end
                SEND: state <= WAIT;
                WAIT: begin
                    if (tx_done) begin
                        if (cnt_q + 5'd1 < total_q) begin
                            cnt_q    <= cnt_q + 5'd1;
                            byte_out <= next_byte;
                            send     <= 1'b1;
                            state    <= SEND;
                            if (n_q > DIM_W'(8) && !k_q) begin
                                k_q <= 1'b1;
                            end else begin
                                k_q <= 1'b0;
                                r_q <= r_q + 1'b1;
                            end
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FIN;
                        end
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/solution_serializer.md
# solution_serializer

Frames the solver's final board for transmission back to the host. On a one-cycle `valid_in` pulse, it captures the solved cell vector and the board dimensions, then emits a byte stream to `uart_tx`, one byte per handshake. The stream is a dimension header followed by row-packed cell bytes. The block sits between `solver` and `uart_tx` in `top_level`; its `done` pulse returns the top-level FSM to RECEIVE.

## Interface
Parameters:
- `MAX_ROWS`, default 11: maximum board rows.
- `MAX_COLS`, default 11: maximum board columns.
- `DIM_W`, default `$clog2(MAX_ROWS)` (4): width of the dimension inputs.

Ports:
- `clk`  in  1  system clock (50 MHz domain).
- `rst`  in  1  reset; **asynchronous, active-low**.
- `valid_in`  in  1  one-cycle pulse: `solution`, `m`, `n` are valid.
- `solution`  in  MAX_ROWS*MAX_COLS  cell (r,c) is bit r*MAX_COLS+c; 1 = filled.
- `m`  in  DIM_W  row count.
- `n`  in  DIM_W  column count.
- `tx_done`  in  1  one-cycle pulse from `uart_tx`: the previous byte has finished.
- `send`  out  1  one-cycle strobe: `byte_out` is to be transmitted.
- `byte_out`  out  8  current frame byte.
- `busy`  out  1  high from capture until `done`.
- `done`  out  1  one-cycle pulse: the frame is complete.

## Operation
- **Frame layout:**
  - Header byte: {m[3:0], n[3:0]}.
  - Row bytes: for each row r = 0..m-1, bpr = (n>8 ? 2 : 1) bytes.
  - Row byte k carries cells c = 8k..8k+7, LSB = lowest c.
  - Bits for c ≥ n are 0.
- **Capture:**
  - `valid_in` in IDLE registers `solution`, `m`, `n`.
  - m > MAX_ROWS clamps to MAX_ROWS; n > MAX_COLS clamps to MAX_COLS.
  - The header reports the clamped values.
- **Frame length:** 1 + m·bpr bytes, maximum 23. The byte counter is 5 bits wide.
- **Empty board:** m==0 or n==0 sends a header-only frame.
- **States:**
  - IDLE → SEND on `valid_in`.
  - SEND: assert `send` for one cycle → WAIT.
  - WAIT: on `tx_done`, advance (byte k, then row r); go to SEND if bytes remain, else FIN.
  - FIN: pulse `done` → IDLE.
- `valid_in` outside IDLE is ignored; the latched frame is unchanged.
- `tx_done` outside WAIT is ignored.
- Byte selection is combinational from latched data and (r, k). `byte_out` is registered on entry to SEND and held until the next SEND.

## Timing
- **Reset values:** `send`=0, `byte_out`=0x00, `busy`=0, `done`=0; state IDLE; all counters 0.
- **Reset mid-frame:** outputs clear asynchronously and the frame is abandoned; no `done` is issued.
- **Start latency:** `valid_in` at cycle t → `send` and header on `byte_out` at t+1; `busy` high from t+1.
- **Inter-byte latency:** `tx_done` at t → next `send` at t+1.
- **Completion:** final `tx_done` at t → `done`=1 and `busy`=0 at t+1. A new `valid_in` is accepted from t+2.
- **Back-to-back frames:** `valid_in` coincident with `done` is ignored.
- **Handshake:** exactly one `send` per byte, and never two `send` strobes without an intervening `tx_done`.

## Configuration
- `SOLUTION_CHECKSUM_EN` defined:
  - A trailing byte is appended: the XOR of all preceding frame bytes, header included.
  - Frame length becomes 1 + m·bpr + 1, maximum 24.
  - A running XOR register updates on each `send`.
- Undefined: no trailing byte and no XOR register.

## Structure
- Package `nonogram_pkg` holds:
  - `MAX_ROWS`, `MAX_COLS`, `DIM_W`;
  - the `ser_state_t` enum (IDLE, SEND, WAIT, FIN);
  - the frame-length function.
- One combinational sub-module, `row_byte_select`, maps (latched solution, r, k, n) to the masked 8-bit row byte.

## Test plan
1. **Small board:** 2×3 board with cells (0,0) and (1,2) set → bytes 0x23, 0x01, 0x04 (with the checksum macro, 0x26 follows); `done` one cycle after the last `tx_done`.
2. **Full board:** 11×11 all ones → 0xBB, then 11× (0xFF, 0x07): 23 bytes; with the checksum macro, 24th byte 0x43.
3. **Slow transmitter:** `tx_done` delayed 500 cycles after each `send` → no extra `send`; `byte_out` stable throughout WAIT.
4. **Mid-frame `valid_in`:** second `valid_in` with different data after byte 2 → ignored; the original frame completes unchanged.
5. **Reset mid-frame:** `rst` low after byte 3 → all outputs 0 immediately, no `done`. After release, a new `valid_in` for a 1×1 board → 0x11, 0x01.
6. **Empty board:** m=0, n=5 → single byte 0x05, then `done`; a spurious `tx_done` while in IDLE produces no `send`.
